// File: rtl/btime_rom_loader.sv
`default_nettype none
// ============================================================================
// btime_rom_loader
//   Checks and splits the HPS ROM download into four regions and owns the
//   Burger Time core reset.
// Revision: 1.0
// ============================================================================
module btime_rom_loader #(
   parameter logic [16:0] R1_BASE        = 17'h0C000,
   parameter logic [16:0] R2_BASE        = 17'h0E000,
   parameter logic [16:0] R3_BASE        = 17'h14000,
   parameter logic [16:0] TOTAL_SIZE     = 17'h1A000,
   parameter int          RELEASE_CYCLES = 16
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        ext_reset,
   input  logic        ioctl_download,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   output logic        dn_wr,
   output logic [16:0] dn_addr,
   output logic [7:0]  dn_data,
   output logic [1:0]  region_sel,
   output logic        game_reset,
   output logic        rom_loaded,
   output logic        dl_error,
   output logic [16:0] byte_count,
   output logic [7:0]  checksum
);

   localparam int            CW       = $clog2(RELEASE_CYCLES + 1);
   localparam logic [CW-1:0] C_RELOAD = CW'(RELEASE_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_HOLD = 2'd2,
      S_RUN  = 2'd3
   } state_t;

   state_t        r_state;
   logic [CW-1:0] r_release_cnt;

   logic        w_in_load;
   logic [16:0] w_cnt_eff;
   logic [7:0]  w_sum_eff;
   logic        w_err_eff;
   logic        w_strobe;
   logic        w_in_order;
   logic        w_in_range;
   logic        w_accept;
   logic        w_fault;
   logic [16:0] w_addr17;
   logic [1:0]  w_region;
   logic [16:0] w_base;

   // Outside LOAD the counters act as already cleared, so the first
   // download-high cycle can accept byte 0 before the state shows LOAD.
   assign w_in_load  = (r_state == S_LOAD);
   assign w_cnt_eff  = w_in_load ? byte_count : 17'd0;
   assign w_sum_eff  = w_in_load ? checksum : 8'd0;
   assign w_err_eff  = w_in_load & dl_error;
   assign w_strobe   = ioctl_download & ioctl_wr & ~w_err_eff;
   assign w_in_order = (ioctl_addr == {8'd0, w_cnt_eff});
   assign w_in_range = (ioctl_addr < {8'd0, TOTAL_SIZE});
   assign w_accept   = w_strobe & w_in_order & w_in_range;
   assign w_fault    = w_strobe & ~(w_in_order & w_in_range);
   assign w_addr17   = ioctl_addr[16:0];

   always_comb begin
      w_region = 2'd0;
      w_base   = 17'd0;
      if (w_addr17 < R1_BASE) begin
         w_region = 2'd0;
         w_base   = 17'd0;
      end else if (w_addr17 < R2_BASE) begin
         w_region = 2'd1;
         w_base   = R1_BASE;
      end else if (w_addr17 < R3_BASE) begin
         w_region = 2'd2;
         w_base   = R2_BASE;
      end else begin
         w_region = 2'd3;
         w_base   = R3_BASE;
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= S_IDLE;
         r_release_cnt <= '0;
         game_reset    <= 1'b1;
         dn_wr         <= 1'b0;
         dn_addr       <= 17'd0;
         dn_data       <= 8'd0;
         region_sel    <= 2'd0;
         rom_loaded    <= 1'b0;
         dl_error      <= 1'b0;
         byte_count    <= 17'd0;
         checksum      <= 8'd0;
      end else begin
         dn_wr <= w_accept;
         if (w_accept) begin
            dn_data    <= ioctl_dout;
            dn_addr    <= w_addr17 - w_base;
            region_sel <= w_region;
         end

         if (ioctl_download) begin
            r_state    <= S_LOAD;
            game_reset <= 1'b1;
            rom_loaded <= 1'b0;
            byte_count <= w_accept ? (w_cnt_eff + 17'd1) : w_cnt_eff;
            checksum   <= w_accept ? (w_sum_eff + ioctl_dout) : w_sum_eff;
            dl_error   <= w_err_eff | w_fault;
         end else begin
            case (r_state)
               S_LOAD: begin
                  if (!dl_error && (byte_count == TOTAL_SIZE)) begin
                     rom_loaded    <= 1'b1;
                     r_release_cnt <= C_RELOAD;
                     r_state       <= S_HOLD;
                  end else begin
                     dl_error <= 1'b1;
                     r_state  <= S_IDLE;
                  end
               end
               S_HOLD: begin
                  if (ext_reset) begin
                     r_release_cnt <= C_RELOAD;
                  end else if (r_release_cnt == '0) begin
                     r_state    <= S_RUN;
                     game_reset <= 1'b0;
                  end else begin
                     r_release_cnt <= r_release_cnt - CW'(1);
                  end
               end
               S_RUN: begin
                  if (ext_reset) begin
                     r_state       <= S_HOLD;
                     r_release_cnt <= C_RELOAD;
                     game_reset    <= 1'b1;
                  end
               end
               default: begin
                  game_reset <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_btime_rom_loader.sv
`default_nettype none
// ============================================================================
// tb_btime_rom_loader
//   Scoreboard bench for btime_rom_loader, run on a scaled-down image map.
// Revision: 1.0
// ============================================================================
module tb_btime_rom_loader;

   // Region bases and image size scaled by 1/256 so a full image stays short.
   localparam logic [16:0] R1    = 17'h000C0;
   localparam logic [16:0] R2    = 17'h000E0;
   localparam logic [16:0] R3    = 17'h00140;
   localparam logic [16:0] TOTAL = 17'h001A0;
   localparam int          REL   = 16;

   logic        clk_sys = 1'b0;
   logic        reset_n = 1'b0;
   logic        ext_reset = 1'b0;
   logic        ioctl_download = 1'b0;
   logic        ioctl_wr = 1'b0;
   logic [24:0] ioctl_addr = '0;
   logic [7:0]  ioctl_dout = '0;
   logic        dn_wr;
   logic [16:0] dn_addr;
   logic [7:0]  dn_data;
   logic [1:0]  region_sel;
   logic        game_reset;
   logic        rom_loaded;
   logic        dl_error;
   logic [16:0] byte_count;
   logic [7:0]  checksum;

   btime_rom_loader #(
      .R1_BASE(R1), .R2_BASE(R2), .R3_BASE(R3),
      .TOTAL_SIZE(TOTAL), .RELEASE_CYCLES(REL)
   ) dut (
      .clk_sys(clk_sys), .reset_n(reset_n), .ext_reset(ext_reset),
      .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
      .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
      .dn_wr(dn_wr), .dn_addr(dn_addr), .dn_data(dn_data),
      .region_sel(region_sel), .game_reset(game_reset),
      .rom_loaded(rom_loaded), .dl_error(dl_error),
      .byte_count(byte_count), .checksum(checksum)
   );

   always #5 clk_sys = ~clk_sys;

   int cyc = 0;
   always @(posedge clk_sys) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;
   int pulses = 0;

   typedef struct {
      logic [26:0] v;
      int          c;
   } sb_t;
   sb_t sbq[$];
   sb_t mon_e;

   logic [16:0] m_count;
   logic [7:0]  m_sum;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [26:0] exp_word(input logic [16:0] a, input logic [7:0] d);
      logic [1:0]  r;
      logic [16:0] b;
      if (a < R1)      begin r = 2'd0; b = 17'd0; end
      else if (a < R2) begin r = 2'd1; b = R1;    end
      else if (a < R3) begin r = 2'd2; b = R2;    end
      else             begin r = 2'd3; b = R3;    end
      return {r, 17'(a - b), d};
   endfunction

   // Every dn_wr pulse must match the oldest expected write, one cycle after its strobe.
   always @(negedge clk_sys) begin
      if (dn_wr === 1'b1) begin
         pulses++;
         chk("sb_pending", 32'(sbq.size() != 0), 32'd1);
         if (sbq.size() != 0) begin
            mon_e = sbq.pop_front();
            chk("sb_word", {5'd0, region_sel, dn_addr, dn_data}, {5'd0, mon_e.v});
            chk("sb_latency", cyc, mon_e.c);
         end
      end
   end

   task automatic step();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic send(input int a, input logic [7:0] d, input bit good);
      sb_t t;
      step();
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'(a);
      ioctl_dout = d;
      if (good) begin
         t.v = exp_word(17'(a), d);
         t.c = cyc + 1;
         sbq.push_back(t);
         m_count++;
         m_sum += d;
      end
   endtask

   // Sends bytes 0..n-1 with data=addr[7:0]; download rises with byte 0.
   task automatic load_seq(input int n, input bit poke_ext);
      m_count = '0;
      m_sum   = '0;
      for (int a = 0; a < n; a++) begin
         send(a, 8'(a), 1'b1);
         if (a == 0) ioctl_download = 1'b1;
         if (poke_ext && a == 5) ext_reset = 1'b1;
         if (poke_ext && a == 8) ext_reset = 1'b0;
      end
   endtask

   task automatic end_dl(output int sample_edge);
      step();
      ioctl_wr       = 1'b0;
      ioctl_download = 1'b0;
      sample_edge    = cyc + 1;
   endtask

   task automatic wait_release(input int sample_edge, input string tag);
      int fall;
      fall = -1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk_sys);
         if (game_reset === 1'b0) begin
            fall = cyc;
            break;
         end
      end
      chk(tag, fall - sample_edge, REL);
   endtask

   task automatic hold_check(input string tag);
      int lows;
      lows = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk_sys);
         if (game_reset !== 1'b1) lows++;
      end
      chk(tag, lows, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int edge_s;
      int p0;

      repeat (3) @(negedge clk_sys);
      chk("rst_game_reset", game_reset, 1);
      chk("rst_dn_wr", dn_wr, 0);
      chk("rst_dn_addr", dn_addr, 0);
      chk("rst_region", region_sel, 0);
      chk("rst_rom_loaded", rom_loaded, 0);
      chk("rst_dl_error", dl_error, 0);
      chk("rst_byte_count", byte_count, 0);
      chk("rst_checksum", checksum, 0);
      step();
      reset_n = 1'b1;

      // Write strobe outside a download is ignored.
      step();
      ioctl_wr = 1'b1; ioctl_addr = '0; ioctl_dout = 8'h55;
      step();
      ioctl_wr = 1'b0;
      @(negedge clk_sys);
      chk("nodl_byte_count", byte_count, 0);
      chk("nodl_dl_error", dl_error, 0);
      chk("nodl_pulses", pulses, 0);

      // Full image, crossing every region boundary; ext_reset pokes during LOAD.
      p0 = pulses;
      load_seq(int'(TOTAL), 1'b1);
      end_dl(edge_s);
      wait_release(edge_s, "load_release");
      chk("load_pulses", pulses - p0, int'(TOTAL));
      chk("load_checksum", checksum, m_sum);
      chk("load_byte_count", byte_count, m_count);
      chk("load_rom_loaded", rom_loaded, 1);
      chk("load_dl_error", dl_error, 0);
      chk("load_sb_empty", sbq.size(), 0);

      // Three-cycle external reset in RUN.
      step();
      ext_reset = 1'b1;
      @(negedge clk_sys);
      chk("stretch_pre", game_reset, 0);
      step();
      @(negedge clk_sys);
      chk("stretch_start", game_reset, 1);
      step();
      step();
      ext_reset = 1'b0;
      wait_release(cyc, "stretch_release");
      chk("stretch_rom_loaded", rom_loaded, 1);

      // Out-of-order address, then an in-order byte that must be dropped.
      p0 = pulses;
      m_count = '0; m_sum = '0;
      send(0, 8'hA1, 1'b1);
      ioctl_download = 1'b1;
      send(1, 8'hB2, 1'b1);
      send(3, 8'hC3, 1'b0);
      send(2, 8'hD4, 1'b0);
      end_dl(edge_s);
      step();
      @(negedge clk_sys);
      chk("ooo_pulses", pulses - p0, 2);
      chk("ooo_dl_error", dl_error, 1);
      chk("ooo_rom_loaded", rom_loaded, 0);
      chk("ooo_byte_count", byte_count, m_count);
      chk("ooo_checksum", checksum, m_sum);
      hold_check("ooo_game_reset_held");

      // Image one byte short.
      load_seq(int'(TOTAL) - 1, 1'b0);
      end_dl(edge_s);
      step();
      @(negedge clk_sys);
      chk("short_dl_error", dl_error, 1);
      chk("short_rom_loaded", rom_loaded, 0);
      chk("short_byte_count", byte_count, int'(TOTAL) - 1);
      hold_check("short_game_reset_held");

      // Full image followed by a byte at TOTAL (out of range).
      load_seq(int'(TOTAL), 1'b0);
      send(int'(TOTAL), 8'h77, 1'b0);
      end_dl(edge_s);
      step();
      @(negedge clk_sys);
      chk("oor_dl_error", dl_error, 1);
      chk("oor_rom_loaded", rom_loaded, 0);
      chk("oor_byte_count", byte_count, TOTAL);

      // Good image, then a reload aborted by reset_n.
      load_seq(int'(TOTAL), 1'b0);
      end_dl(edge_s);
      wait_release(edge_s, "reload_release");
      chk("reload_rom_loaded", rom_loaded, 1);
      load_seq(100, 1'b0);
      step();
      ioctl_wr = 1'b0;
      step();
      p0 = pulses;
      reset_n = 1'b0;
      #1;
      chk("abort_game_reset", game_reset, 1);
      chk("abort_dn_wr", dn_wr, 0);
      chk("abort_dn_addr", dn_addr, 0);
      chk("abort_dn_data", dn_data, 0);
      chk("abort_region", region_sel, 0);
      chk("abort_rom_loaded", rom_loaded, 0);
      chk("abort_dl_error", dl_error, 0);
      chk("abort_byte_count", byte_count, 0);
      chk("abort_checksum", checksum, 0);
      for (int i = 0; i < 5; i++) send(100 + i, 8'(i), 1'b0);
      step();
      ioctl_wr = 1'b0;
      ioctl_download = 1'b0;
      step();
      reset_n = 1'b1;
      step();
      @(negedge clk_sys);
      chk("abort_pulses", pulses - p0, 0);
      chk("abort_sb_empty", sbq.size(), 0);

      // A fresh download after the abort restarts from byte 0.
      load_seq(3, 1'b0);
      end_dl(edge_s);
      step();
      @(negedge clk_sys);
      chk("restart_byte_count", byte_count, m_count);
      chk("restart_checksum", checksum, m_sum);
      chk("restart_sb_empty", sbq.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/btime_rom_loader.md
Name: btime_rom_loader

Overview:
Sequences the HPS ROM download stream into the Burger Time core and owns the core's reset. It checks address order and image size, splits the flat image into four ROM regions with region-relative addresses, and accumulates a checksum. It holds the game in reset while no valid image is loaded, and it stretches external reset requests. It sits between hps_io and burger_time, replacing the direct ioctl_* to dn_* wiring and the OR-ed reset.

Parameters:
R1_BASE, 17'h0C000, first byte of region 1 (sound CPU ROM); region 0 (main CPU ROM) starts at 0
R2_BASE, 17'h0E000, first byte of region 2 (tile/char ROM)
R3_BASE, 17'h14000, first byte of region 3 (sprite/bg ROM)
TOTAL_SIZE, 17'h1A000, exact image length in bytes
RELEASE_CYCLES, 16, number of clk_sys cycles game_reset stays high after a load or an external reset ends (must be >= 1)

Ports:
clk_sys  in  1  system clock (12 MHz); all logic on its rising edge
reset_n  in  1  asynchronous, active-low reset
ext_reset  in  1  active-high reset request (RESET | status[0] | buttons[1]), sampled synchronously
ioctl_download  in  1  download window active
ioctl_wr  in  1  byte strobe, one cycle per byte
ioctl_addr  in  25  byte address from hps_io
ioctl_dout  in  8  byte data
dn_wr  out  1  one-cycle write pulse to the ROM array
dn_addr  out  17  address relative to the base of the selected region
dn_data  out  8  write data
region_sel  out  2  region of the current dn_wr (0..3)
game_reset  out  1  active-high reset to burger_time
rom_loaded  out  1  a complete, error-free image is resident
dl_error  out  1  sticky fault from the last download
byte_count  out  17  bytes accepted in the current or last download
checksum  out  8  mod-256 sum of the bytes accepted

Behaviour:
- Async reset values: state=IDLE, game_reset=1, dn_wr=0, dn_addr=0, dn_data=0, region_sel=0, rom_loaded=0, dl_error=0, byte_count=0, checksum=0, release counter=0.
- States:
  - IDLE: no valid image; game_reset=1.
  - LOAD: download window open; game_reset=1.
  - HOLD: counting down the release period; game_reset=1.
  - RUN: game active; game_reset=0.
- Transitions:
  - Any state, ioctl_download=1 while not in LOAD -> LOAD. Entering LOAD clears byte_count, checksum, dl_error and rom_loaded.
  - LOAD, ioctl_download=0:
    - if dl_error=0 and byte_count==TOTAL_SIZE: rom_loaded<=1, counter<=RELEASE_CYCLES-1, -> HOLD.
    - otherwise: dl_error<=1, -> IDLE.
  - HOLD: the counter decrements each cycle; at 0 -> RUN. ext_reset=1 reloads the counter.
  - RUN, ext_reset=1 -> HOLD with the counter reloaded; rom_loaded is unchanged.
  - IDLE ignores ext_reset.
- Write acceptance:
  - A byte is accepted when ioctl_download=1 && ioctl_wr=1 && dl_error=0 && ioctl_addr==byte_count && ioctl_addr<TOTAL_SIZE.
  - This applies on the very first download-high cycle, before the state register shows LOAD.
- Faults:
  - If ioctl_wr=1 during download and the address check fails (out of order or >= TOTAL_SIZE), set dl_error.
  - Once dl_error is set, later bytes of that download are dropped.
  - ioctl_wr while ioctl_download=0 is ignored, with no error.
- Outputs for an accepted byte, all registered one cycle after the strobe:
  - dn_wr=1 for exactly one cycle.
  - dn_data=ioctl_dout.
  - region_sel: 0 if addr<R1_BASE, 1 if <R2_BASE, 2 if <R3_BASE, else 3.
  - dn_addr = addr minus that region's base, computed as a 17-bit subtraction.
  - byte_count increments by 1; checksum<=checksum+ioctl_dout, wrapping mod 256.
- When no byte is accepted: dn_wr=0; dn_addr, dn_data and region_sel hold their last values.
- Boundary cases:
  - An accepted write on the final download-high cycle still produces its dn_wr, and it counts toward the size check.
  - ext_reset during LOAD has no effect.
  - reset_n asserted mid-download returns to IDLE with everything cleared; a later download-high cycle restarts LOAD.

Test Plan:
- Full sequential load: bytes 0..0x19FFF with data=addr[7:0], then drop download -> 0x1A000 dn_wr pulses; checksum=0x00; rom_loaded=1; game_reset falls exactly 16 cycles after download falls.
- Region split: writes at 0x0BFFF, 0x0C000, 0x0E000 and 0x14005 -> (region_sel, dn_addr) = (0,0x0BFFF), (1,0x0000), (2,0x0000), (3,0x0005), each one cycle after its strobe.
- Out-of-order byte: addresses 0,1,3 -> only 2 dn_wr pulses; dl_error=1; at download end state is IDLE, rom_loaded=0, game_reset=1.
- Short image: stop at byte_count=0x19FFF -> dl_error=1, rom_loaded=0, game_reset stays 1.
- Reset stretch: in RUN, pulse ext_reset for 3 cycles -> game_reset high from the cycle after the first ext_reset sample until 16 cycles after the last; rom_loaded stays 1.
- Reload and abort: with an image loaded, raise download, send 100 bytes, assert reset_n=0 -> all outputs return to reset values immediately, with no further dn_wr.
